// File: rtl/minimig_zorro_mapper.sv
`default_nettype none
// ============================================================================
// Module   : minimig_zorro_mapper
// Purpose  : Zorro II/III autoconfig chain sequencer and board window decoder.
// Revision : 1.0 - initial release
// ============================================================================
module minimig_zorro_mapper #(
  parameter logic [3:0] Z3_MASK = 4'b0110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic [7:0]  address_in,
  input  logic [15:0] data_in,
  input  logic        hwr,
  input  logic        lwr,
  input  logic        sel,
  input  logic [3:0]  board_present,
  input  logic [15:0] board_size,
  input  logic [15:0] cpu_addr,
  output logic [2:0]  cur_board,
  output logic [3:0]  board_configured,
  output logic [3:0]  board_shutup,
  output logic [3:0]  ram_sel,
  output logic        autoconfig_done
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CHAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [8:0] c_OFF_BASE_HI = 9'h044;
  localparam logic [8:0] c_OFF_BASE_LO = 9'h048;
  localparam logic [8:0] c_OFF_SHUTUP  = 9'h04C;
  localparam logic [2:0] c_NULL_BOARD  = 3'b111;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_present;
  logic [2:0]  r_cur_board, w_cur_nxt;
  logic [3:0]  r_configured, r_shutup, r_ram_sel, w_hit;
  logic        r_done, w_done_nxt;
  logic [15:0] r_base [4];

  logic [8:0]  w_off;
  logic [7:0]  w_byte;
  logic [1:0]  w_idx;
  logic        w_is_z3, w_wr;
  logic        w_wr_lo, w_wr_hi, w_clr_hi, w_mark_cfg, w_mark_shut, w_adv;
  logic        w_unused;

  assign w_off    = {address_in, 1'b0};
  assign w_byte   = data_in[15:8];
  assign w_idx    = r_cur_board[1:0];
  assign w_is_z3  = Z3_MASK[w_idx];
  assign w_wr     = clk7_en & sel & hwr & (r_state == ST_CHAIN);
  assign w_unused = ^{lwr, data_in[7:0]};

  // Lowest populated slot at or above lo; null when the chain has run out.
  function automatic logic [2:0] next_present(input logic [3:0] pres, input int lo);
    logic [2:0] w_found;
    w_found = c_NULL_BOARD;
    for (int i = 3; i >= 0; i--) begin
      if (pres[i] && i >= lo) w_found = 3'(i);
    end
    return w_found;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_board;
    w_done_nxt  = r_done;
    w_wr_lo     = 1'b0;
    w_wr_hi     = 1'b0;
    w_clr_hi    = 1'b0;
    w_mark_cfg  = 1'b0;
    w_mark_shut = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_cur_nxt = next_present(board_present, 0);
        if (board_present == 4'b0000) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_CHAIN;
        end
      end
      ST_CHAIN: begin
        if (w_wr) begin
          if (w_off == c_OFF_SHUTUP) begin
            w_mark_shut = 1'b1;
            w_adv       = 1'b1;
          end else if (w_off == c_OFF_BASE_LO) begin
            // Z3 boards take $48 as the low byte and wait for $44 to finish.
            w_wr_lo = 1'b1;
            if (!w_is_z3) begin
              w_clr_hi   = 1'b1;
              w_mark_cfg = 1'b1;
              w_adv      = 1'b1;
            end
          end else if (w_off == c_OFF_BASE_HI && w_is_z3) begin
            w_wr_hi    = 1'b1;
            w_mark_cfg = 1'b1;
            w_adv      = 1'b1;
          end
          if (w_adv) begin
            w_cur_nxt = next_present(r_present, int'(r_cur_board) + 1);
            if (w_cur_nxt == c_NULL_BOARD) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_cur_board  <= c_NULL_BOARD;
      r_present    <= 4'b0000;
      r_configured <= 4'b0000;
      r_shutup     <= 4'b0000;
      r_done       <= 1'b0;
      r_ram_sel    <= 4'b0000;
      for (int i = 0; i < 4; i++) r_base[i] <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_board <= w_cur_nxt;
      r_done      <= w_done_nxt;
      r_ram_sel   <= w_hit;
      if (r_state == ST_INIT) r_present <= board_present;
      if (w_mark_cfg)  r_configured[w_idx] <= 1'b1;
      if (w_mark_shut) r_shutup[w_idx]     <= 1'b1;
      if (w_wr_lo)     r_base[w_idx][7:0]  <= w_byte;
      if (w_wr_hi)     r_base[w_idx][15:8] <= w_byte;
      if (w_clr_hi)    r_base[w_idx][15:8] <= 8'h00;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_decode
    logic [3:0]  w_n;
    logic [15:0] w_mask;
    logic        w_z2_ok;
    assign w_n     = (board_size[4*i +: 4] > 4'd12) ? 4'd12 : board_size[4*i +: 4];
    assign w_mask  = 16'hFFFF << w_n;
    // Z2 windows live below 16 MB, so the top address byte must be clear.
    assign w_z2_ok = Z3_MASK[i] | (cpu_addr[15:8] == 8'h00);
    assign w_hit[i] = r_configured[i] & w_z2_ok &
                      ((cpu_addr & w_mask) == (r_base[i] & w_mask));
  end

  assign cur_board        = r_cur_board;
  assign board_configured = r_configured;
  assign board_shutup     = r_shutup;
  assign ram_sel          = r_ram_sel;
  assign autoconfig_done  = r_done;

endmodule
`default_nettype wire
